tage_update_sched: RTL

Schedules committed-branch training updates into the four-bank TAGE predictor. Buffers commit-stage update requests in a small FIFO, issues at most one update per cycle onto the predictor's single update port, and stalls issue while the fetch side holds the tables with `pause`. Owns the periodic useful-bit aging policy: generates the alternating `flush_ubits_hi` / `flush_ubits_lo` pulses from a count of issued updates. Sits between the commit stage and the TAGE predictor in the IFU.

---
 rtl/tage_update_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tage_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : tage_update_sched
// Description : Commit-to-TAGE update scheduler. Buffers committed-branch
//               training updates in a DEPTH-entry FIFO, issues at most one
//               per cycle onto the predictor update port, stalls on pause,
//               and generates alternating useful-bit aging pulses every
//               UFLUSH_PERIOD issued updates.
//               Optional feature macro: TAGE_UPDATE_BYPASS_EN (empty-FIFO
//               same-cycle bypass from input to update port).
//               Reset input rst is asynchronous and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module tage_update_sched #(
    parameter int DEPTH         = 4,
    parameter int UFLUSH_PERIOD = 256,
    parameter int PRED_W        = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              pause,
    input  wire logic              in_valid,
    output logic                   in_ready,
    input  wire logic              in_taken,
    input  wire logic [31:0]       in_pc,
    input  wire logic [PRED_W-1:0] in_pred,
    input  wire logic              in_mispred,
    output logic                   commit_valid,
    output logic                   committed_branch_taken,
    output logic [31:0]            committed_pc,
    output logic [PRED_W-1:0]      committed_pred_info,
    output logic                   committed_mispred,
    output logic                   flush_ubits_hi,
    output logic                   flush_ubits_lo,
    output logic                   overflow
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;
    localparam int c_UW = (UFLUSH_PERIOD > 1) ? $clog2(UFLUSH_PERIOD) : 1;
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_UW-1:0] c_UCNT_MAX = c_UW'(UFLUSH_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // FIFO storage, split per field
    logic              r_mem_taken   [DEPTH];
    logic [31:0]       r_mem_pc      [DEPTH];
    logic [PRED_W-1:0] r_mem_pred    [DEPTH];
    logic              r_mem_mispred [DEPTH];

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_in_ready;
    logic            r_overflow;
    logic [c_UW-1:0] r_ucnt;
    logic            r_phase_hi;
    state_t          r_state;
    state_t          w_state_next;

    logic            w_empty;
    logic            w_flush_cycle;
    logic            w_fifo_issue;
    logic            w_bypass;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_ucnt_wrap;
    logic [c_CW-1:0] w_count_next;

    assign w_empty       = (r_count == '0);
    assign w_flush_cycle = (r_state == S_FLUSH);
    assign w_fifo_issue  = !w_empty && !pause && !w_flush_cycle;

`ifdef TAGE_UPDATE_BYPASS_EN
    // An empty, free-running scheduler forwards the request straight through.
    assign w_bypass = w_empty && !pause && !w_flush_cycle && in_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_issue     = w_fifo_issue || w_bypass;
    assign w_pop       = w_fifo_issue;
    // A bypassed request is consumed directly and never occupies an entry.
    assign w_push      = in_valid && r_in_ready && !w_bypass;
    assign w_ucnt_wrap = w_issue && (r_ucnt == c_UCNT_MAX);

    assign in_ready = r_in_ready;
    assign overflow = r_overflow;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    // FIFO storage, pointers, occupancy, registered ready and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_taken[i]   <= 1'b0;
                r_mem_pc[i]      <= '0;
                r_mem_pred[i]    <= '0;
                r_mem_mispred[i] <= 1'b0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_taken[r_wr_ptr]   <= in_taken;
                r_mem_pc[r_wr_ptr]      <= in_pc;
                r_mem_pred[r_wr_ptr]    <= in_pred;
                r_mem_mispred[r_wr_ptr] <= in_mispred;
                r_wr_ptr                <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count    <= w_count_next;
            // Ready is a pure register so it never depends on this cycle's pop.
            r_in_ready <= (w_count_next != c_FULL);
            if (in_valid && !r_in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Aging counter of issued updates and hi/lo flush phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ucnt     <= '0;
            r_phase_hi <= 1'b1;
        end else begin
            if (w_ucnt_wrap) begin
                r_ucnt <= '0;
            end else if (w_issue) begin
                r_ucnt <= r_ucnt + c_UW'(1);
            end
            if (w_flush_cycle) begin
                r_phase_hi <= !r_phase_hi;
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, issue strobe, flush pulses and head/bypass data selection
    always_comb begin
        w_state_next           = r_state;
        commit_valid           = w_issue;
        flush_ubits_hi         = w_flush_cycle && r_phase_hi;
        flush_ubits_lo         = w_flush_cycle && !r_phase_hi;
        committed_branch_taken = r_mem_taken[r_rd_ptr];
        committed_pc           = r_mem_pc[r_rd_ptr];
        committed_pred_info    = r_mem_pred[r_rd_ptr];
        committed_mispred      = r_mem_mispred[r_rd_ptr];

        if (w_bypass) begin
            committed_branch_taken = in_taken;
            committed_pc           = in_pc;
            committed_pred_info    = in_pred;
            committed_mispred      = in_mispred;
        end

        // Flush takes the cycle after the wrapping issue; otherwise the state
        // follows occupancy and pause.
        if (w_ucnt_wrap) begin
            w_state_next = S_FLUSH;
        end else if (w_count_next == '0) begin
            w_state_next = S_IDLE;
        end else if (pause) begin
            w_state_next = S_HOLD;
        end else begin
            w_state_next = S_ISSUE;
        end
    end

endmodule
`default_nettype wire
